// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and decode helpers for the configurable UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    function automatic logic [3:0] dw_bits(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx synchroniser, start-edge detect and 3-sample majority vote
module uart_rx_sampler (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    input  logic sample,
    output logic rx_sync,
    output logic fall_edge,
    output logic vote
);

    logic       meta;
    logic       sync_q;
    logic       prev;
    logic [1:0] samp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b1;
            sync_q <= 1'b1;
            prev   <= 1'b1;
            samp   <= 2'b11;
        end else begin
            meta   <= rx;
            sync_q <= meta;
            prev   <= sync_q;
            if (sample)
                samp <= {samp[0], sync_q};
        end
    end

    assign rx_sync   = sync_q;
    assign fall_edge = prev & ~sync_q;
    // The third sample is the live synced value, so the vote is valid on the third sample tick
    assign vote = (samp[1] & samp[0]) | (samp[1] & sync_q) | (samp[0] & sync_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - runtime-configurable UART receiver with valid/ready holding register
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int OVS    = 16,
    parameter int MAX_DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              rx,
    input  logic              en,
    input  logic [1:0]        cfg_dw,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_stop2,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [MAX_DW-1:0] m_data,
    output logic              m_perr,
    output logic              m_ferr,
    output logic              overrun,
    output logic              break_det,
    output logic              busy
);

    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] S0   = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] S1   = CW'(OVS / 2);
    localparam logic [CW-1:0] S2   = CW'(OVS / 2 + 1);
    localparam logic [CW-1:0] LAST = CW'(OVS - 1);

    rx_state_t     state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [3:0]    dw_r;
    logic [1:0]    par_r;
    logic          stop2_r, stop_idx, perr_r, ferr_r, par_bit;
    logic          rx_sync, fall_edge, vote, sample;
    logic          at_vote, at_end, par_en, active;
    logic          complete, is_break, frame_ferr;

    assign active  = (state == ST_START) || (state == ST_DATA) ||
                     (state == ST_PARITY) || (state == ST_STOP);
    assign at_vote = tick && (cnt == S2);
    assign at_end  = tick && (cnt == LAST);
    assign sample  = tick && active && ((cnt == S0) || (cnt == S1) || (cnt == S2));
    assign par_en  = (par_r == PAR_ODD) || (par_r == PAR_EVEN);
    assign busy    = (state != ST_IDLE);

    uart_rx_sampler u_sampler (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .sample    (sample),
        .rx_sync   (rx_sync),
        .fall_edge (fall_edge),
        .vote      (vote)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n    = state;
        complete   = 1'b0;
        is_break   = 1'b0;
        frame_ferr = ferr_r | ~vote;
        if (state != ST_IDLE && !en) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (en && fall_edge) state_n = ST_START;
                ST_START: begin
                    if (at_vote && vote)
                        state_n = ST_IDLE;
                    else if (at_end)
                        state_n = ST_DATA;
                end
                ST_DATA:
                    if (at_end && ({1'b0, bit_idx} == dw_r - 4'd1))
                        state_n = par_en ? ST_PARITY : ST_STOP;
                ST_PARITY:   if (at_end) state_n = ST_STOP;
                ST_STOP: begin
                    // Completion happens at the vote, leaving half a bit to catch the next start edge
                    if (at_vote) begin
                        if (!stop_idx && shreg == 8'd0 && (!par_en || !par_bit) && !vote) begin
                            is_break = 1'b1;
                            complete = 1'b1;
                            state_n  = ST_BRK_WAIT;
                        end else if (stop_idx == stop2_r) begin
                            complete = 1'b1;
                            state_n  = ST_IDLE;
                        end
                    end
                end
                ST_BRK_WAIT: if (rx_sync) state_n = ST_IDLE;
                default:     state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'd0;
            dw_r      <= 4'd0;
            par_r     <= PAR_NONE;
            stop2_r   <= 1'b0;
            stop_idx  <= 1'b0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
            par_bit   <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_perr    <= 1'b0;
            m_ferr    <= 1'b0;
            overrun   <= 1'b0;
            break_det <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            break_det <= 1'b0;
            if (state == ST_IDLE && state_n == ST_START) begin
                cnt      <= '0;
                bit_idx  <= 3'd0;
                shreg    <= 8'd0;
                dw_r     <= dw_bits(cfg_dw);
                par_r    <= cfg_parity;
                stop2_r  <= cfg_stop2;
                stop_idx <= 1'b0;
                perr_r   <= 1'b0;
                ferr_r   <= 1'b0;
                par_bit  <= 1'b0;
            end else if (tick && active) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                if (at_vote) begin
                    case (state)
                        ST_DATA:   shreg[bit_idx] <= vote;
                        ST_PARITY: begin
                            par_bit <= vote;
                            perr_r  <= (par_r == PAR_ODD) ? ~(^shreg ^ vote) : (^shreg ^ vote);
                        end
                        ST_STOP:   ferr_r <= frame_ferr;
                        default:   ;
                    endcase
                end
                if (at_end) begin
                    case (state)
                        ST_DATA: bit_idx  <= bit_idx + 3'd1;
                        ST_STOP: stop_idx <= 1'b1;
                        default: ;
                    endcase
                end
            end
            if (complete && (!m_valid || m_ready)) begin
                m_data  <= MAX_DW'(shreg);
                m_perr  <= perr_r;
                m_ferr  <= frame_ferr;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (complete && m_valid && !m_ready)
                overrun <= 1'b1;
            if (is_break)
                break_det <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed self-checking bench for uart_rx_cfg
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick;
    logic       rx = 1'b1;
    logic       en = 1'b1;
    logic [1:0] cfg_dw = 2'd3;
    logic [1:0] cfg_parity = 2'd0;
    logic       cfg_stop2 = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_perr, m_ferr, overrun, break_det, busy;

    logic [1:0] div = 2'd0;
    int ncmp = 0;
    int nfail = 0;
    int vcyc = 0, nacc = 0, novr = 0, nbrk = 0;
    logic [7:0] last_data = 8'd0;
    logic last_perr = 1'b0, last_ferr = 1'b0;

    uart_rx_cfg #(.OVS(16), .MAX_DW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .rx         (rx),
        .en         (en),
        .cfg_dw     (cfg_dw),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_perr     (m_perr),
        .m_ferr     (m_ferr),
        .overrun    (overrun),
        .break_det  (break_det),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) div <= div + 2'd1;
    assign tick = (div == 2'd3);

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid) vcyc++;
            if (m_valid && m_ready) begin
                nacc++;
                last_data = m_data;
                last_perr = m_perr;
                last_ferr = m_ferr;
            end
            if (overrun) novr++;
            if (break_det) nbrk++;
        end
    end

    task automatic wait_one_tick();
        do @(negedge clk); while (!tick);
    endtask

    task automatic idle_ticks(input int n);
        rx = 1'b1;
        repeat (n) wait_one_tick();
    endtask

    task automatic send_raw(input logic [15:0] bits, input int n, input int gbit, input int gtick);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 16; k++) begin
                rx = bits[i] ^ ((i == gbit) && (k == gtick));
                wait_one_tick();
            end
        end
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        ncmp++; if (m_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b exp 0", m_valid); end
        ncmp++; if (m_data !== 8'h00) begin nfail++; $display("FAIL reset_data: got %h exp 00", m_data); end
        ncmp++; if ({m_perr, m_ferr, overrun, break_det} !== 4'b0000) begin
            nfail++; $display("FAIL reset_flags: got %b exp 0000", {m_perr, m_ferr, overrun, break_det}); end
        ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b exp 0", busy); end
        rst_n = 1'b1;
        idle_ticks(16);
    endtask

    task automatic test_basic();
        int a0, v0;
        a0 = nacc; v0 = vcyc;
        send_raw({1'b1, 8'hA5, 1'b0}, 10, -1, -1);
        idle_ticks(16);
        ncmp++; if (nacc - a0 !== 1) begin nfail++; $display("FAIL basic_count: got %0d exp 1", nacc - a0); end
        ncmp++; if (last_data !== 8'hA5) begin nfail++; $display("FAIL basic_data: got %h exp a5", last_data); end
        ncmp++; if ({last_perr, last_ferr} !== 2'b00) begin nfail++; $display("FAIL basic_flags: got %b exp 00", {last_perr, last_ferr}); end
        ncmp++; if (vcyc - v0 !== 1) begin nfail++; $display("FAIL basic_valid_cycles: got %0d exp 1", vcyc - v0); end
    endtask

    task automatic test_7e2_parity();
        int a0;
        a0 = nacc;
        cfg_dw = 2'd2; cfg_parity = 2'd2; cfg_stop2 = 1'b1;
        // 0x55 in 7 bits has four ones, so even parity should be 0; send 1
        send_raw({2'b11, 1'b1, 7'h55, 1'b0}, 11, -1, -1);
        cfg_dw = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        idle_ticks(16);
        ncmp++; if (nacc - a0 !== 1) begin nfail++; $display("FAIL par_count: got %0d exp 1", nacc - a0); end
        ncmp++; if (last_data !== 8'h55) begin nfail++; $display("FAIL par_data: got %h exp 55", last_data); end
        ncmp++; if (last_perr !== 1'b1) begin nfail++; $display("FAIL par_perr: got %b exp 1", last_perr); end
        ncmp++; if (last_ferr !== 1'b0) begin nfail++; $display("FAIL par_ferr: got %b exp 0", last_ferr); end
    endtask

    task automatic test_false_start();
        int a0, v0;
        a0 = nacc; v0 = vcyc;
        rx = 1'b0;
        repeat (5) wait_one_tick();
        idle_ticks(32);
        ncmp++; if (vcyc - v0 !== 0) begin nfail++; $display("FAIL false_valid: got %0d exp 0", vcyc - v0); end
        ncmp++; if (nacc - a0 !== 0) begin nfail++; $display("FAIL false_count: got %0d exp 0", nacc - a0); end
        ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL false_busy: got %b exp 0", busy); end
    endtask

    task automatic test_glitch();
        int a0, b0;
        a0 = nacc; b0 = nbrk;
        send_raw({1'b1, 8'h00, 1'b0}, 10, 4, 8);
        idle_ticks(16);
        ncmp++; if (nacc - a0 !== 1) begin nfail++; $display("FAIL glitch_count: got %0d exp 1", nacc - a0); end
        ncmp++; if (last_data !== 8'h00) begin nfail++; $display("FAIL glitch_data: got %h exp 00", last_data); end
        ncmp++; if ({last_perr, last_ferr} !== 2'b00) begin nfail++; $display("FAIL glitch_flags: got %b exp 00", {last_perr, last_ferr}); end
        ncmp++; if (nbrk - b0 !== 0) begin nfail++; $display("FAIL glitch_break: got %0d exp 0", nbrk - b0); end
    endtask

    task automatic test_abort();
        int a0;
        a0 = nacc;
        send_raw({1'b1, 8'hFF, 1'b0}, 4, -1, -1);
        en = 1'b0;
        repeat (3) @(negedge clk);
        ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL abort_busy: got %b exp 0", busy); end
        idle_ticks(16);
        en = 1'b1;
        idle_ticks(32);
        ncmp++; if (nacc - a0 !== 0) begin nfail++; $display("FAIL abort_count: got %0d exp 0", nacc - a0); end
        send_raw({1'b1, 8'h5A, 1'b0}, 10, -1, -1);
        idle_ticks(16);
        ncmp++; if (last_data !== 8'h5A) begin nfail++; $display("FAIL abort_recover: got %h exp 5a", last_data); end
    endtask

    task automatic test_overrun();
        int a0, o0;
        a0 = nacc; o0 = novr;
        m_ready = 1'b0;
        send_raw({1'b1, 8'h11, 1'b0}, 10, -1, -1);
        idle_ticks(8);
        send_raw({1'b1, 8'h22, 1'b0}, 10, -1, -1);
        idle_ticks(16);
        ncmp++; if (m_valid !== 1'b1) begin nfail++; $display("FAIL ovr_valid: got %b exp 1", m_valid); end
        ncmp++; if (m_data !== 8'h11) begin nfail++; $display("FAIL ovr_held: got %h exp 11", m_data); end
        ncmp++; if (novr - o0 !== 1) begin nfail++; $display("FAIL ovr_pulses: got %0d exp 1", novr - o0); end
        @(posedge clk); #1;
        m_ready = 1'b1;
        repeat (4) @(negedge clk);
        ncmp++; if (nacc - a0 !== 1) begin nfail++; $display("FAIL ovr_drain_count: got %0d exp 1", nacc - a0); end
        ncmp++; if (last_data !== 8'h11) begin nfail++; $display("FAIL ovr_drain_data: got %h exp 11", last_data); end
        ncmp++; if (m_valid !== 1'b0) begin nfail++; $display("FAIL ovr_drained: got %b exp 0", m_valid); end
    endtask

    task automatic test_break();
        int a0, b0;
        a0 = nacc; b0 = nbrk;
        rx = 1'b0;
        repeat (320) wait_one_tick();
        ncmp++; if (nbrk - b0 !== 1) begin nfail++; $display("FAIL brk_pulses: got %0d exp 1", nbrk - b0); end
        ncmp++; if (nacc - a0 !== 1) begin nfail++; $display("FAIL brk_count: got %0d exp 1", nacc - a0); end
        ncmp++; if (last_data !== 8'h00) begin nfail++; $display("FAIL brk_data: got %h exp 00", last_data); end
        ncmp++; if ({last_perr, last_ferr} !== 2'b01) begin nfail++; $display("FAIL brk_flags: got %b exp 01", {last_perr, last_ferr}); end
        ncmp++; if (busy !== 1'b1) begin nfail++; $display("FAIL brk_wait_busy: got %b exp 1", busy); end
        idle_ticks(32);
        ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL brk_release: got %b exp 0", busy); end
        send_raw({1'b1, 8'h3C, 1'b0}, 10, -1, -1);
        idle_ticks(16);
        ncmp++; if (nacc - a0 !== 2) begin nfail++; $display("FAIL brk_next_count: got %0d exp 2", nacc - a0); end
        ncmp++; if (last_data !== 8'h3C) begin nfail++; $display("FAIL brk_next_data: got %h exp 3c", last_data); end
        ncmp++; if (last_ferr !== 1'b0) begin nfail++; $display("FAIL brk_next_ferr: got %b exp 0", last_ferr); end
        ncmp++; if (nbrk - b0 !== 1) begin nfail++; $display("FAIL brk_total: got %0d exp 1", nbrk - b0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_7e2_parity();
        test_false_start();
        test_glitch();
        test_abort();
        test_overrun();
        test_break();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
